// File: rtl/cdr_link_pkg.sv
// Shared types and constants for the link-layer deframer behind the Manchester CDR.
package cdr_link_pkg;
  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CRC     = 2'd2
  } dfr_state_e;

  localparam logic [7:0] SYNC_WORD_DEF = 8'hD5;
  localparam logic [7:0] CRC_POLY_DEF  = 8'h07;
  localparam logic [7:0] CRC_INIT_DEF  = 8'h00;

  // Chip pairs as {first_chip, second_chip}
  localparam logic [1:0] CHIP_ONE  = 2'b10;
  localparam logic [1:0] CHIP_ZERO = 2'b01;
endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8, MSB-first, no reflection, no final xor.
module crc8_serial
  import cdr_link_pkg::*;
#(
  parameter logic [7:0] CRC_POLY = CRC_POLY_DEF,
  parameter logic [7:0] CRC_INIT = CRC_INIT_DEF
) (
  input  logic       clk_link,
  input  logic       rst_n,
  input  logic       init,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc_out
);
  logic fb;
  assign fb = crc_out[7] ^ bit_in;

  always_ff @(posedge clk_link or negedge rst_n) begin
    if (!rst_n)    crc_out <= CRC_INIT;
    else if (init) crc_out <= CRC_INIT;
    else if (en)   crc_out <= {crc_out[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  end
endmodule

// File: rtl/manchester_frame_deframer.sv
// Pairs Manchester chips into bits, hunts for the sync byte, collects a fixed
// payload plus CRC-8 and emits one validated word per frame.
module manchester_frame_deframer
  import cdr_link_pkg::*;
#(
  parameter int         DATA_W    = 32,
  parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter logic [7:0] CRC_POLY  = CRC_POLY_DEF,
  parameter logic [7:0] CRC_INIT  = CRC_INIT_DEF
) (
  input  logic              clk_link,
  input  logic              rst_n,
  input  logic              chip_in,
  input  logic              chip_valid,
  input  logic              cdr_locked,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              crc_err,
  output logic              frame_err,
  output logic              in_frame
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  dfr_state_e        state, state_n;
  logic              chip_phase, first_chip;
  logic [6:0]        sync_sr;   // last 7 decoded bits; the 8th is the bit in flight
  logic [6:0]        rx_crc;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] payload;
  logic [7:0]        crc_val;

  logic [1:0] pair;
  logic       pair_evt, pair_one, pair_viol, bit_evt, sync_hit;
  logic       last_payload, last_crc, crc_match;
  logic       dv_n, ce_n, fe_n, crc_init, crc_en;

  assign pair         = {first_chip, chip_in};
  assign pair_evt     = cdr_locked && chip_valid && chip_phase;
  assign pair_one     = (pair == CHIP_ONE);
  assign pair_viol    = (pair != CHIP_ONE) && (pair != CHIP_ZERO);
  assign bit_evt      = pair_evt && !pair_viol;
  assign sync_hit     = (state == HUNT) && bit_evt && ({sync_sr, pair_one} == SYNC_WORD);
  assign last_payload = (bit_cnt == CNT_W'(DATA_W - 1));
  assign last_crc     = (bit_cnt == CNT_W'(7));
  assign crc_match    = ({rx_crc, pair_one} == crc_val);

  crc8_serial #(.CRC_POLY(CRC_POLY), .CRC_INIT(CRC_INIT)) u_crc (
    .clk_link (clk_link),
    .rst_n    (rst_n),
    .init     (crc_init),
    .en       (crc_en),
    .bit_in   (pair_one),
    .crc_out  (crc_val)
  );

  always_comb begin
    state_n  = state;
    dv_n     = 1'b0;
    ce_n     = 1'b0;
    fe_n     = 1'b0;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    if (!cdr_locked) begin
      state_n = HUNT;
      fe_n    = (state != HUNT);
    end else if (pair_evt) begin
      if (pair_viol) begin
        if (state != HUNT) begin
          state_n = HUNT;
          fe_n    = 1'b1;
        end
      end else begin
        unique case (state)
          HUNT: if (sync_hit) begin
            state_n  = PAYLOAD;
            crc_init = 1'b1;
          end
          PAYLOAD: begin
            crc_en = 1'b1;
            if (last_payload) state_n = CRC;
          end
          CRC: if (last_crc) begin
            state_n = HUNT;
            dv_n    = crc_match;
            ce_n    = !crc_match;
          end
          default: state_n = HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clk_link or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      chip_phase <= 1'b0;
      first_chip <= 1'b0;
      sync_sr    <= '0;
      rx_crc     <= '0;
      bit_cnt    <= '0;
      payload    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      crc_err    <= 1'b0;
      frame_err  <= 1'b0;
      in_frame   <= 1'b0;
    end else begin
      state      <= state_n;
      data_valid <= dv_n;
      crc_err    <= ce_n;
      frame_err  <= fe_n;
      in_frame   <= (state_n != HUNT);
      if (dv_n) data_out <= payload;
      if (!cdr_locked) begin
        chip_phase <= 1'b0;
        sync_sr    <= '0;
      end else if (chip_valid) begin
        if (!chip_phase) begin
          first_chip <= chip_in;
          chip_phase <= 1'b1;
        end else if (pair_viol) begin
          // In HUNT a bad pair means we are on the wrong chip boundary: slide by one.
          if (state == HUNT) begin
            first_chip <= chip_in;
          end else begin
            chip_phase <= 1'b0;
            sync_sr    <= '0;
          end
        end else begin
          chip_phase <= 1'b0;
          unique case (state)
            HUNT: begin
              sync_sr <= sync_hit ? 7'd0 : {sync_sr[5:0], pair_one};
              if (sync_hit) bit_cnt <= '0;
            end
            PAYLOAD: begin
              payload <= {payload[DATA_W-2:0], pair_one};
              bit_cnt <= last_payload ? '0 : bit_cnt + CNT_W'(1);
            end
            CRC: begin
              rx_crc  <= {rx_crc[5:0], pair_one};
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_manchester_frame_deframer.sv
// Directed + randomized frames against a polynomial-division CRC reference.
`timescale 1ns/1ps
module tb_manchester_frame_deframer;
  localparam int DATA_W = 32;

  logic              clk_link = 1'b0;
  logic              rst_n = 1'b0;
  logic              chip_in = 1'b0;
  logic              chip_valid = 1'b0;
  logic              cdr_locked = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              data_valid, crc_err, frame_err, in_frame;

  int checks = 0;
  int failures = 0;
  int dv_cnt = 0, ce_cnt = 0, fe_cnt = 0;
  int pulse_n;
  logic [DATA_W-1:0] exp_dout;

  manchester_frame_deframer #(.DATA_W(DATA_W)) dut (
    .clk_link   (clk_link),
    .rst_n      (rst_n),
    .chip_in    (chip_in),
    .chip_valid (chip_valid),
    .cdr_locked (cdr_locked),
    .data_out   (data_out),
    .data_valid (data_valid),
    .crc_err    (crc_err),
    .frame_err  (frame_err),
    .in_frame   (in_frame)
  );

  always #2.5 clk_link = ~clk_link;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse bookkeeping: every cycle with a pulse must carry exactly one.
  always @(negedge clk_link) begin
    if (rst_n) begin
      pulse_n = int'(data_valid) + int'(crc_err) + int'(frame_err);
      dv_cnt += int'(data_valid);
      ce_cnt += int'(crc_err);
      fe_cnt += int'(frame_err);
      if (pulse_n != 0) chk("pulse_onehot", 64'(pulse_n), 64'd1);
    end
  end

  // Remainder of payload * x^8 divided by x^8+x^2+x+1 (seed 0).
  function automatic logic [7:0] crc8_ref(input logic [DATA_W-1:0] d);
    logic [DATA_W+7:0] r;
    r = {d, 8'h00};
    for (int i = DATA_W + 7; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0];
  endfunction

  task automatic send_chip(input logic c, input int gap);
    chip_in    = c;
    chip_valid = 1'b1;
    @(negedge clk_link);
    chip_valid = 1'b0;
    repeat (gap) @(negedge clk_link);
  endtask

  task automatic send_bit(input logic b, input bit last);
    send_chip(b, int'($urandom_range(0, 1)));
    send_chip(~b, last ? 0 : int'($urandom_range(0, 1)));
  endtask

  task automatic send_bits(input logic [63:0] v, input int n, input bit last);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], last && (i == 0));
  endtask

  task automatic send_preamble(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1, 1'b0);
  endtask

  task automatic run_frame(input logic [DATA_W-1:0] p, input logic [7:0] c, input string tag);
    int dv0, ce0, fe0;
    bit good;
    dv0 = dv_cnt; ce0 = ce_cnt; fe0 = fe_cnt;
    send_preamble(2 + int'($urandom_range(0, 3)));
    send_bits(64'hD5, 8, 1'b1);
    chk({tag, "_in_frame_rise"}, in_frame, 1);
    send_bits(64'(p), DATA_W, 1'b0);
    send_bits(64'(c), 8, 1'b1);
    good = (c == crc8_ref(p));
    if (good) exp_dout = p;
    chk({tag, "_data_valid"}, data_valid, good);
    chk({tag, "_crc_err"}, crc_err, !good);
    chk({tag, "_data_out"}, data_out, exp_dout);
    chk({tag, "_in_frame_fall"}, in_frame, 0);
    @(negedge clk_link);
    chk({tag, "_dv_count"}, 64'(dv_cnt - dv0), good ? 1 : 0);
    chk({tag, "_ce_count"}, 64'(ce_cnt - ce0), good ? 0 : 1);
    chk({tag, "_fe_count"}, 64'(fe_cnt - fe0), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dv0, fe0;
    logic [DATA_W-1:0] p;
    logic [7:0] c;
    exp_dout = '0;
    repeat (3) @(negedge clk_link);
    chk("rst_data_out", data_out, 0);
    chk("rst_pulses", {data_valid, crc_err, frame_err}, 0);
    chk("rst_in_frame", in_frame, 0);
    rst_n = 1'b1;
    cdr_locked = 1'b1;
    @(negedge clk_link);

    run_frame(32'h00000001, 8'h07, "t1_good");
    run_frame(32'h00000000, 8'h01, "t2_crcbad");

    // One stray chip ahead of the stream forces a single slip during hunt
    send_chip(1'b1, 0);
    run_frame(32'h00000001, 8'h07, "t3_slip");

    // Manchester violation at payload bit 10
    dv0 = dv_cnt; fe0 = fe_cnt;
    p = $urandom;
    send_preamble(3);
    send_bits(64'hD5, 8, 1'b0);
    send_bits(64'(p >> (DATA_W - 10)), 10, 1'b0);
    send_chip(1'b1, 1);
    send_chip(1'b1, 0);
    chk("t4_frame_err", frame_err, 1);
    chk("t4_in_frame", in_frame, 0);
    @(negedge clk_link);
    chk("t4_fe_count", 64'(fe_cnt - fe0), 1);
    chk("t4_dv_count", 64'(dv_cnt - dv0), 0);
    p = $urandom;
    run_frame(p, crc8_ref(p), "t4_recover");

    // Lock loss mid-payload coinciding with a chip strobe
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_preamble(2);
    send_bits(64'hD5, 8, 1'b0);
    send_bits(64'hA5A, 12, 1'b0);
    cdr_locked = 1'b0;
    send_chip(1'b1, 0);
    chk("t5_frame_err", frame_err, 1);
    chk("t5_in_frame", in_frame, 0);
    for (int i = 0; i < 5; i++) send_chip(i[0], 1);
    chk("t5_fe_count", 64'(fe_cnt - fe0), 1);
    chk("t5_dv_count", 64'(dv_cnt - dv0), 0);
    cdr_locked = 1'b1;
    @(negedge clk_link);
    run_frame(32'h00000001, 8'h07, "t5_relock");

    // Asynchronous reset in the middle of the CRC field
    p = $urandom;
    send_preamble(2);
    send_bits(64'hD5, 8, 1'b0);
    send_bits(64'(p), DATA_W, 1'b0);
    send_bits(64'(crc8_ref(p) >> 5), 3, 1'b0);
    #1 rst_n = 1'b0;
    #0.5;
    chk("t6_rst_data_out", data_out, 0);
    chk("t6_rst_pulses", {data_valid, crc_err, frame_err}, 0);
    chk("t6_rst_in_frame", in_frame, 0);
    exp_dout = '0;
    @(negedge clk_link);
    rst_n = 1'b1;
    @(negedge clk_link);
    run_frame(32'h00000001, 8'h07, "t6_after_rst");

    for (int k = 0; k < 10; k++) begin
      p = $urandom;
      c = crc8_ref(p);
      if ($urandom_range(0, 2) == 0) c = c ^ 8'($urandom_range(1, 255));
      run_frame(p, c, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/manchester_frame_deframer.md
Name: manchester_frame_deframer

Overview:
Sits directly downstream of the 4x-oversampling CDR in the clk_link (200 MHz) domain. It consumes the recovered Manchester chip stream (one chip per chip_valid pulse) and pairs chips into data bits, slipping chip alignment on Manchester violations. It hunts for a sync byte, assembles a fixed-length payload, checks a serial CRC-8, and emits one validated word per frame.

Parameters:
DATA_W, 32, payload bits per frame (multiple of 8, 8..64)
SYNC_WORD, 8'hD5, frame delimiter, MSB first
CRC_POLY, 8'h07, CRC-8 polynomial (x^8+x^2+x+1)
CRC_INIT, 8'h00, CRC seed loaded at sync detect

Ports:
clk_link  in  1  200 MHz link clock
rst_n  in  1  asynchronous active-low reset
chip_in  in  1  recovered Manchester chip (CDR bit_out)
chip_valid  in  1  1-cycle strobe, chip_in valid (CDR bit_valid)
cdr_locked  in  1  CDR lock status
data_out  out  DATA_W  last CRC-good payload, MSB = first received bit
data_valid  out  1  1-cycle pulse, data_out updated
crc_err  out  1  1-cycle pulse, frame complete but CRC mismatch
frame_err  out  1  1-cycle pulse, frame aborted (violation or lock loss)
in_frame  out  1  high in PAYLOAD/CRC states

Behaviour:
- Reset (async, rst_n=0): state HUNT, chip_phase=0, first_chip=0, sync_sr=0, crc=CRC_INIT, bit_cnt=0, data_out=0, all pulses 0, in_frame=0.
- Chip pairing: on chip_valid with chip_phase=0, store first_chip and set chip_phase=1. On chip_valid with chip_phase=1, evaluate pair and set chip_phase=0. Pair "10" -> bit 1, "01" -> bit 0; "00"/"11" -> violation.
- Violation in HUNT: slip alignment by one chip. The current chip becomes first_chip and chip_phase stays 1. sync_sr is unchanged.
- Violation in PAYLOAD/CRC: frame_err pulse, go to HUNT, chip_phase=0, sync_sr=0.
- States:
  - HUNT: each decoded bit shifts into sync_sr (MSB first). When {sync_sr[6:0],bit}==SYNC_WORD, go to PAYLOAD, crc=CRC_INIT, bit_cnt=0, sync_sr=0.
  - PAYLOAD: each bit shifts into the payload register and feeds the CRC. Serial CRC: fb=crc[7]^bit; crc={crc[6:0],1'b0}^(fb?CRC_POLY:0). After DATA_W bits, go to CRC with bit_cnt=0.
  - CRC: 8 bits shift into rx_crc, MSB first. On the 8th bit, compare rx_crc with the computed crc.
    - Match: data_out<=payload, data_valid=1.
    - Mismatch: crc_err=1 and data_out is unchanged.
    - Either way, go to HUNT. Every frame requires its own sync; back-to-back frames are legal with zero gap.
- Latency: data_valid/crc_err assert exactly 1 clk_link after the chip_valid that carries the second chip of the last CRC bit.
- cdr_locked=0 has priority over chip_valid in the same cycle:
  - Force HUNT, chip_phase=0, sync_sr=0.
  - frame_err pulses once if the block was in PAYLOAD or CRC; no pulse if already in HUNT.
  - Held in this state while locked is low.
- Pulses never overlap: at most one of data_valid/crc_err/frame_err per cycle.
- in_frame is registered; it rises the cycle after sync detect and falls the cycle after frame end or abort.
- Counters: bit_cnt is $clog2(DATA_W+1) bits wide, with no wrap inside a frame.

Decomposition:
- Package cdr_link_pkg holds:
  - the deframer state enum (HUNT, PAYLOAD, CRC);
  - SYNC_WORD, CRC_POLY, CRC_INIT defaults;
  - chip-pair encoding constants (CHIP_ONE=2'b10, CHIP_ZERO=2'b01).
- One sub-module, crc8_serial:
  - ports: clk_link, rst_n, init, en, bit_in, crc_out;
  - parameters: CRC_POLY, CRC_INIT.
- The pairing/slip logic and FSM stay in the top module.

Test Plan:
1. Locked CDR, chips for sync 0xD5 + payload 0x00000001 + CRC 0x07 -> data_valid pulse 1 clk after final chip, data_out=32'h00000001, no error pulses.
2. Sync 0xD5 + payload 0x00000000 + CRC 0x01 (expected 0x00) -> crc_err single pulse, data_out keeps prior value 32'h00000001, in_frame falls.
3. Start stream one chip misaligned (extra leading chip "1"), then idle "10" pairs and frame with payload 0x00000001 -> one slip on first violation, then frame decoded, data_valid with 32'h00000001.
4. Inject chip pair "11" at payload bit 10 -> frame_err pulse, in_frame low next cycle, no data_valid; the following well-formed frame decodes correctly.
5. Deassert cdr_locked mid-payload on a cycle with chip_valid=1 -> exactly one frame_err, chip ignored, state HUNT; relock and resend 0x00000001 frame -> data_valid.
6. Assert rst_n=0 mid-CRC field -> all outputs 0 immediately (async); after release, a full frame decodes with no spurious pulses.
